ball_flight_ctrl: RTL and testbench

BALL_FLIGHT_CTRL -- requirements
Module: ball_flight_ctrl

---
 rtl/foosball_pkg.sv | 22 ++
 rtl/step_divider.sv | 38 +++
 rtl/ball_flight_ctrl.sv | 129 ++++++++++++
 tb/tb_ball_flight_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/foosball_pkg.sv
// Shared types and constants for the foosball ball-flight controller.
package foosball_pkg;

    localparam int unsigned ScoreW           = 4;
    localparam int unsigned CoordW           = 11;
    localparam int unsigned GoalLeftDefault  = 100;
    localparam int unsigned GoalRightDefault = 600;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StServe    = 3'd1,
        StFlight   = 3'd2,
        StGoalHold = 3'd3,
        StGameOver = 3'd4
    } state_e;

    function automatic logic [ScoreW-1:0] sat_inc(input logic [ScoreW-1:0] s,
                                                  input logic [ScoreW-1:0] lim);
        return (s >= lim) ? lim : s + 1'b1;
    endfunction

endpackage

// File: rtl/step_divider.sv
// Counts tick pulses and emits a registered one-cycle strobe on every FRAMES-th tick.
module step_divider #(
    parameter int unsigned FRAMES = 1
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic clear,
    input  logic tick,
    output logic strobe
);

    localparam logic [3:0] Last = 4'(FRAMES - 1);

    logic [3:0] cnt_q;
    logic       strobe_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (cnt_q == Last) begin
                    cnt_q    <= '0;
                    strobe_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/ball_flight_ctrl.sv
// Rally sequencing for one ball: serve, paced flight with bounces, goal hold and scoring.
module ball_flight_ctrl
    import foosball_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned GOAL_LEFT_X     = GoalLeftDefault,
    parameter int unsigned GOAL_RIGHT_X    = GoalRightDefault,
    parameter int unsigned HOLD_FRAMES     = 60,
    parameter int unsigned WIN_SCORE       = 9
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              start_of_frame,
    input  logic              serve_req,
    input  logic              hit_rod,
    input  logic              hit_wall_y,
    input  logic [CoordW-1:0] ball_x,
    output logic              step_en,
    output logic              x_dir,
    output logic              y_dir,
    output logic              mover_rst_n,
    output logic [ScoreW-1:0] score_left,
    output logic [ScoreW-1:0] score_right,
    output logic [2:0]        state,
    output logic              game_over
);

    localparam logic [CoordW-1:0] GoalL = CoordW'(GOAL_LEFT_X);
    localparam logic [CoordW-1:0] GoalR = CoordW'(GOAL_RIGHT_X);
    localparam logic [ScoreW-1:0] Win   = ScoreW'(WIN_SCORE);
    localparam logic [7:0]        Hold  = 8'(HOLD_FRAMES);

    state_e            state_q, state_d;
    logic [ScoreW-1:0] score_left_q, score_right_q;
    logic [7:0]        hold_q;
    logic              x_dir_q, y_dir_q, mover_rst_n_q, game_over_q;
    logic              conceded_left_q;
    logic              div_strobe;
    logic              goal_left, goal_right;

    assign goal_left  = (ball_x <= GoalL);
    assign goal_right = (ball_x >= GoalR);

    step_divider #(
        .FRAMES(FRAMES_PER_STEP)
    ) u_step_divider (
        .CLK   (CLK),
        .RESETn(RESETn),
        .clear (state_q != StFlight),
        .tick  (start_of_frame),
        .strobe(div_strobe)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (serve_req) state_d = StServe;
            StServe:    state_d = StFlight;
            StFlight:   if (goal_left || goal_right) state_d = StGoalHold;
            StGoalHold: begin
                if (hold_q == 8'd0) begin
                    state_d = (score_left_q == Win || score_right_q == Win) ? StGameOver
                                                                           : StServe;
                end
            end
            StGameOver: if (serve_req) state_d = StServe;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q         <= StIdle;
            score_left_q    <= '0;
            score_right_q   <= '0;
            hold_q          <= '0;
            x_dir_q         <= 1'b0;
            y_dir_q         <= 1'b0;
            mover_rst_n_q   <= 1'b0;
            game_over_q     <= 1'b0;
            conceded_left_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mover_rst_n_q <= !(state_d == StServe ||
                               (state_d == StGoalHold && state_q != StGoalHold));
            game_over_q   <= (state_d == StGameOver);
            unique case (state_q)
                StFlight: begin
                    // A goal wins over any bounce arriving in the same cycle.
                    if (goal_left) begin
                        score_right_q   <= sat_inc(score_right_q, Win);
                        conceded_left_q <= 1'b1;
                        hold_q          <= Hold;
                    end else if (goal_right) begin
                        score_left_q    <= sat_inc(score_left_q, Win);
                        conceded_left_q <= 1'b0;
                        hold_q          <= Hold;
                    end else begin
                        if (hit_rod)    x_dir_q <= ~x_dir_q;
                        if (hit_wall_y) y_dir_q <= ~y_dir_q;
                    end
                end
                StGoalHold: if (hold_q != 8'd0 && start_of_frame) hold_q <= hold_q - 8'd1;
                StGameOver: begin
                    if (serve_req) begin
                        score_left_q  <= '0;
                        score_right_q <= '0;
                    end
                end
                default: ;
            endcase
            // Serve launches the ball toward whoever conceded last.
            if (state_d == StServe) begin
                x_dir_q <= conceded_left_q;
                y_dir_q <= 1'b0;
            end
        end
    end

    assign step_en     = div_strobe && (state_q == StFlight);
    assign x_dir       = x_dir_q;
    assign y_dir       = y_dir_q;
    assign mover_rst_n = mover_rst_n_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign state       = state_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_ball_flight_ctrl.sv
// Directed bench for ball_flight_ctrl: serve, pacing, bounces, goals, game over and reset.
module tb_ball_flight_ctrl;
    import foosball_pkg::*;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic        start_of_frame = 1'b0;
    logic        serve_req = 1'b0;
    logic        hit_rod = 1'b0;
    logic        hit_wall_y = 1'b0;
    logic [10:0] ball_x = 11'd300;
    logic        step_en, x_dir, y_dir, mover_rst_n, game_over;
    logic [3:0]  score_left, score_right;
    logic [2:0]  state;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    ball_flight_ctrl #(
        .FRAMES_PER_STEP(2),
        .HOLD_FRAMES    (60),
        .WIN_SCORE      (2)
    ) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .start_of_frame(start_of_frame),
        .serve_req     (serve_req),
        .hit_rod       (hit_rod),
        .hit_wall_y    (hit_wall_y),
        .ball_x        (ball_x),
        .step_en       (step_en),
        .x_dir         (x_dir),
        .y_dir         (y_dir),
        .mover_rst_n   (mover_rst_n),
        .score_left    (score_left),
        .score_right   (score_right),
        .state         (state),
        .game_over     (game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic frame();
        start_of_frame = 1'b1;
        clk1();
        start_of_frame = 1'b0;
        clk1();
        clk1();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(StIdle));
        chk({tag, "_mrst"}, 32'(mover_rst_n), 32'd0);
        chk({tag, "_step"}, 32'(step_en), 32'd0);
        chk({tag, "_sl"}, 32'(score_left), 32'd0);
        chk({tag, "_sr"}, 32'(score_right), 32'd0);
        chk({tag, "_xy"}, {30'd0, x_dir, y_dir}, 32'd0);
        chk({tag, "_go"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        // Asynchronous reset takes effect without a clock edge.
        #1 RESETn = 1'b0;
        #1 chk_reset_outputs("rst");
        clk1();
        clk1();
        @(negedge CLK);
        RESETn = 1'b1;
        clk1();
        chk("rel_state", 32'(state), 32'(StIdle));
        chk("rel_mrst", 32'(mover_rst_n), 32'd1);

        // First serve: one cycle, recentre pulse, x_dir=0.
        serve_req = 1'b1;
        clk1();
        serve_req = 1'b0;
        chk("serve_state", 32'(state), 32'(StServe));
        chk("serve_mrst", 32'(mover_rst_n), 32'd0);
        chk("serve_xdir", 32'(x_dir), 32'd0);
        clk1();
        chk("flight_state", 32'(state), 32'(StFlight));
        chk("flight_mrst", 32'(mover_rst_n), 32'd1);
        chk("flight_step0", 32'(step_en), 32'd0);

        // Divide-by-2 pacing.
        start_of_frame = 1'b1; clk1(); start_of_frame = 1'b0;
        chk("div_f1", 32'(step_en), 32'd0);
        start_of_frame = 1'b1; clk1(); start_of_frame = 1'b0;
        chk("div_f2", 32'(step_en), 32'd1);
        clk1();
        chk("div_f2_end", 32'(step_en), 32'd0);

        // Bounces coinciding with step_en: old directions shown, toggled after.
        start_of_frame = 1'b1; clk1(); start_of_frame = 1'b0;
        start_of_frame = 1'b1; clk1(); start_of_frame = 1'b0;
        hit_rod = 1'b1;
        hit_wall_y = 1'b1;
        #1;
        chk("coinc_step", 32'(step_en), 32'd1);
        chk("coinc_olddir", {30'd0, x_dir, y_dir}, 32'd0);
        clk1();
        hit_rod = 1'b0;
        hit_wall_y = 1'b0;
        chk("coinc_newdir", {30'd0, x_dir, y_dir}, 32'd3);
        chk("coinc_step_end", 32'(step_en), 32'd0);
        hit_wall_y = 1'b1; clk1(); hit_wall_y = 1'b0;
        chk("wall_only", {30'd0, x_dir, y_dir}, 32'd2);
        hit_rod = 1'b1; clk1(); hit_rod = 1'b0;
        chk("rod_only", {30'd0, x_dir, y_dir}, 32'd0);

        // Left goal with a simultaneous rod hit: goal wins.
        ball_x = 11'd100;
        hit_rod = 1'b1;
        clk1();
        hit_rod = 1'b0;
        ball_x = 11'd300;
        chk("goalL_state", 32'(state), 32'(StGoalHold));
        chk("goalL_sr", 32'(score_right), 32'd1);
        chk("goalL_xdir", 32'(x_dir), 32'd0);
        chk("goalL_mrst", 32'(mover_rst_n), 32'd0);
        hit_rod = 1'b1; clk1(); hit_rod = 1'b0;
        chk("hold_mrst", 32'(mover_rst_n), 32'd1);
        chk("hold_ignore_hit", 32'(x_dir), 32'd0);
        for (int i = 0; i < 59; i++) frame();
        chk("hold_59", 32'(state), 32'(StGoalHold));
        start_of_frame = 1'b1; clk1(); start_of_frame = 1'b0;
        chk("hold_60", 32'(state), 32'(StGoalHold));
        clk1();
        chk("reserve_state", 32'(state), 32'(StServe));
        chk("reserve_xdir", 32'(x_dir), 32'd1);
        chk("reserve_mrst", 32'(mover_rst_n), 32'd0);
        clk1();

        // Two right goals reach WIN_SCORE=2.
        ball_x = 11'd600; clk1(); ball_x = 11'd300;
        chk("goalR1_sl", 32'(score_left), 32'd1);
        for (int i = 0; i < 60; i++) frame();
        chk("after_hold1_state", 32'(state), 32'(StFlight));
        chk("after_hold1_xdir", 32'(x_dir), 32'd0);
        ball_x = 11'd600; clk1(); ball_x = 11'd300;
        chk("goalR2_sl", 32'(score_left), 32'd2);
        for (int i = 0; i < 60; i++) frame();
        chk("over_state", 32'(state), 32'(StGameOver));
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_scores", {24'd0, score_left, score_right}, 32'h21);
        serve_req = 1'b1; clk1(); serve_req = 1'b0;
        chk("restart_state", 32'(state), 32'(StServe));
        chk("restart_scores", {24'd0, score_left, score_right}, 32'h00);
        chk("restart_go", 32'(game_over), 32'd0);
        clk1();

        // Reset in the middle of a goal hold.
        ball_x = 11'd100; clk1(); ball_x = 11'd300;
        chk("goalL2_sr", 32'(score_right), 32'd1);
        frame();
        frame();
        #2 RESETn = 1'b0;
        #1 chk_reset_outputs("midrst");
        clk1();
        @(negedge CLK);
        RESETn = 1'b1;
        clk1();
        chk("midrst_rel_state", 32'(state), 32'(StIdle));
        chk("midrst_rel_mrst", 32'(mover_rst_n), 32'd1);
        serve_req = 1'b1; clk1(); serve_req = 1'b0;
        chk("midrst_serve_xdir", 32'(x_dir), 32'd0);
        chk("midrst_scores", {24'd0, score_left, score_right}, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
